// File: rtl/bcd_counter_mux_seg_pkg.sv
// Shared BCD constants and the 7-segment code table used by the counter
// and its display decoder. Segment codes are active-high {g,f,e,d,c,b,a}.
package bcd_counter_mux_seg_pkg;

  localparam logic [3:0] BCD_ZERO  = 4'd0;
  localparam logic [3:0] BCD_NINE  = 4'd9;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b0111111;
      4'd1:    seg_code = 7'b0000110;
      4'd2:    seg_code = 7'b1011011;
      4'd3:    seg_code = 7'b1001111;
      4'd4:    seg_code = 7'b1100110;
      4'd5:    seg_code = 7'b1101101;
      4'd6:    seg_code = 7'b1111101;
      4'd7:    seg_code = 7'b0000111;
      4'd8:    seg_code = 7'b1111111;
      4'd9:    seg_code = 7'b1101111;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit. cy flags that this digit wraps on the current step,
// so the next digit moves in the same cycle.
module bcd_digit
  import bcd_counter_mux_seg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  output logic [3:0] q,
  output logic       cy
);

  assign cy = (inc && q == BCD_NINE) || (dec && q == BCD_ZERO);

  always_ff @(posedge clk) begin
    if (!rst)     q <= BCD_ZERO;
    else if (clr) q <= BCD_ZERO;
    else if (inc) q <= (q == BCD_NINE) ? BCD_ZERO : q + 4'd1;
    else if (dec) q <= (q == BCD_ZERO) ? BCD_NINE : q - 4'd1;
  end

endmodule

// File: rtl/bcd_counter_mux_seg.sv
// Cascaded BCD up/down counter with prescaled tick and a time-multiplexed
// 7-segment display driver with optional leading-zero blanking.
module bcd_counter_mux_seg
  import bcd_counter_mux_seg_pkg::*;
#(
  parameter int unsigned NDIGITS    = 4,
  parameter int unsigned DIV_WIDTH  = 25,
  parameter int unsigned SCAN_WIDTH = 16,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter bit          BLANK_LZ   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   up_dn,
  input  logic                   clr,
  output logic [4*NDIGITS-1:0]   bcd,
  output logic                   carry,
  output logic [6:0]             seg,
  output logic [NDIGITS-1:0]     an
);

  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic [DIV_WIDTH-1:0]  div;
  logic [SCAN_WIDTH-1:0] scan;
  logic [IDX_W-1:0]      idx;
  logic                  tick, step, wrap;

  assign tick = &div;
  // en/up_dn only matter on tick cycles; clr suppresses the step and carry.
  assign step = tick && en && !clr;

  always_ff @(posedge clk) begin
    if (!rst)     div <= '0;
    else if (clr) div <= '0;
    else          div <= div + 1'b1;
  end

  for (genvar g = 0; g < NDIGITS; g++) begin : g_dig
    logic inc_i, dec_i, cy_i;
    if (g == 0) begin : g_first
      assign inc_i = step && up_dn;
      assign dec_i = step && !up_dn;
    end else begin : g_next
      assign inc_i = g_dig[g-1].inc_i && g_dig[g-1].cy_i;
      assign dec_i = g_dig[g-1].dec_i && g_dig[g-1].cy_i;
    end
    bcd_digit u_digit (
      .clk (clk),
      .rst (rst),
      .inc (inc_i),
      .dec (dec_i),
      .clr (clr),
      .q   (bcd[4*g +: 4]),
      .cy  (cy_i)
    );
  end

  assign wrap = g_dig[NDIGITS-1].cy_i;

  always_ff @(posedge clk) begin
    if (!rst) carry <= 1'b0;
    else      carry <= wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scan <= '0;
      idx  <= '0;
    end else begin
      scan <= scan + 1'b1;
      if (&scan) idx <= (idx == IDX_W'(NDIGITS-1)) ? '0 : idx + 1'b1;
    end
  end

  logic [3:0]         cur;
  logic               hi_zero;
  logic [NDIGITS-1:0] oh;
  logic [6:0]         pat;

  // A digit is a leading zero when it and everything above it are zero.
  always_comb begin
    cur     = BCD_ZERO;
    hi_zero = 1'b0;
    oh      = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur     = bcd[4*i +: 4];
        hi_zero = (i != 0) && ((bcd >> (4*i)) == '0);
        oh[i]   = 1'b1;
      end
    end
    pat = (BLANK_LZ && hi_zero) ? SEG_BLANK : seg_code(cur);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      seg <= ACTIVE_LOW ? '1 : '0;
      an  <= ACTIVE_LOW ? '1 : '0;
    end else begin
      seg <= ACTIVE_LOW ? ~pat : pat;
      an  <= ACTIVE_LOW ? ~oh : oh;
    end
  end

endmodule

// File: tb/tb_bcd_counter_mux_seg.sv
// Two configurations of the counter/display driven from shared inputs and
// scored cycle by cycle against an arithmetic reference model.
module tb_bcd_counter_mux_seg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, en = 1'b0, up_dn = 1'b1, clr = 1'b0;

  logic [7:0]  bcd_a;  logic carry_a; logic [6:0] seg_a; logic [1:0] an_a;
  logic [15:0] bcd_b;  logic carry_b; logic [6:0] seg_b; logic [3:0] an_b;

  bcd_counter_mux_seg #(.NDIGITS(2), .DIV_WIDTH(2), .SCAN_WIDTH(2),
                        .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr),
    .bcd(bcd_a), .carry(carry_a), .seg(seg_a), .an(an_a));

  bcd_counter_mux_seg #(.NDIGITS(4), .DIV_WIDTH(1), .SCAN_WIDTH(1),
                        .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr),
    .bcd(bcd_b), .carry(carry_b), .seg(seg_b), .an(an_b));

  typedef struct packed {
    logic [15:0] bcd;
    logic        carry;
    logic [6:0]  seg;
    logic [3:0]  an;
  } exp_t;

  exp_t q_a[$], q_b[$];
  int checks = 0, errors = 0;

  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111};
  int nd[2]  = '{2, 4};
  int dw[2]  = '{2, 1};
  int sw[2]  = '{2, 1};
  int al[2]  = '{0, 1};
  int blz[2] = '{0, 1};
  int m_cnt[2], m_div[2], m_scan[2], m_idx[2];

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r *= 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v, input int n);
    logic [15:0] r = '0;
    for (int i = 0; i < n; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  // Expected outputs after this edge, from the count as a plain integer.
  task automatic model_step(input int k, output exp_t e);
    int m, p, digit;
    logic [6:0] s;
    logic [3:0] a, mask;
    m    = pow10(nd[k]);
    mask = 4'((1 << nd[k]) - 1);
    e.carry = 1'b0;
    if (!rst) begin
      m_cnt[k] = 0; m_div[k] = 0; m_scan[k] = 0; m_idx[k] = 0;
      e.seg = (al[k] != 0) ? 7'h7f : 7'h00;
      e.an  = (al[k] != 0) ? mask : 4'h0;
    end else begin
      p     = pow10(m_idx[k]);
      digit = (m_cnt[k] / p) % 10;
      s     = seg_tab[digit];
      if (blz[k] != 0 && m_idx[k] > 0 && m_cnt[k] / p == 0) s = 7'h00;
      a     = 4'(1 << m_idx[k]);
      e.seg = (al[k] != 0) ? ~s : s;
      e.an  = (al[k] != 0) ? (~a & mask) : a;
      if (clr) begin
        m_cnt[k] = 0; m_div[k] = 0;
      end else begin
        if (m_div[k] == (1 << dw[k]) - 1 && en) begin
          if (up_dn) begin
            e.carry  = (m_cnt[k] == m - 1);
            m_cnt[k] = (m_cnt[k] + 1) % m;
          end else begin
            e.carry  = (m_cnt[k] == 0);
            m_cnt[k] = (m_cnt[k] + m - 1) % m;
          end
        end
        m_div[k] = (m_div[k] + 1) % (1 << dw[k]);
      end
      if (m_scan[k] == (1 << sw[k]) - 1) m_idx[k] = (m_idx[k] + 1) % nd[k];
      m_scan[k] = (m_scan[k] + 1) % (1 << sw[k]);
    end
    e.bcd = to_bcd(m_cnt[k], nd[k]);
  endtask

  task automatic check(input string nm, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t got bcd=%h carry=%b seg=%b an=%b want bcd=%h carry=%b seg=%b an=%b",
               nm, $time, act.bcd, act.carry, act.seg, act.an,
               exp.bcd, exp.carry, exp.seg, exp.an);
    end
  endtask

  function automatic exp_t act_a();
    exp_t r;
    r.bcd = {8'h00, bcd_a}; r.carry = carry_a; r.seg = seg_a; r.an = {2'b00, an_a};
    return r;
  endfunction

  function automatic exp_t act_b();
    exp_t r;
    r.bcd = bcd_b; r.carry = carry_b; r.seg = seg_b; r.an = an_b;
    return r;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    model_step(0, e); q_a.push_back(e);
    model_step(1, e); q_b.push_back(e);
  end

  always @(negedge clk) begin
    if (q_a.size() > 0) check("scoreboard_a", act_a(), q_a.pop_front());
    if (q_b.size() > 0) check("scoreboard_b", act_b(), q_b.pop_front());
  end

  task automatic bound_fail(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (wait bound expired)", nm, got, want);
    end
  endtask

  initial begin
    exp_t r;
    repeat (2) @(posedge clk);
    @(negedge clk);
    r = '{bcd: 16'h0, carry: 1'b0, seg: 7'h00, an: 4'h0};
    check("reset_a", act_a(), r);
    r = '{bcd: 16'h0, carry: 1'b0, seg: 7'h7f, an: 4'hf};
    check("reset_b", act_b(), r);

    // Count up through a full two-digit wrap.
    @(posedge clk); #1 rst = 1'b1; en = 1'b1; up_dn = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    // Run the four-digit counter to 0305 then freeze it to scan the display.
    for (int c = 0; c < 2000 && m_cnt[1] != 305; c++) begin
      @(posedge clk); #1;
    end
    en = 1'b0;
    bound_fail("reach_0305", m_cnt[1], 305);
    repeat (24) @(posedge clk);

    // Down from zero wraps to all nines.
    #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0; en = 1'b1; up_dn = 1'b0;
    repeat (30) @(posedge clk);

    // clr coincident with the 99 -> 00 tick must not produce carry.
    #1 up_dn = 1'b1;
    for (int c = 0; c < 1000 && !(m_cnt[0] == 99 && m_div[0] == 3); c++) begin
      @(posedge clk); #1;
    end
    bound_fail("reach_99_tick", m_cnt[0] * 10 + m_div[0], 993);
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    repeat (10) @(posedge clk);

    // en held low across several ticks.
    #1 en = 1'b0;
    repeat (12) @(posedge clk);
    #1 en = 1'b1;

    // Reset in the middle of counting.
    repeat (37) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (20) @(posedge clk);

    for (int c = 0; c < 3000; c++) begin
      #1;
      en  = ($urandom % 4) != 0;
      if (($urandom % 16) == 0) up_dn = ~up_dn;
      clr = ($urandom % 64) == 0;
      rst = ($urandom % 200) != 0;
      @(posedge clk);
    end
    #1 rst = 1'b1; clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
